// File: rtl/pipelined_adder_if.sv
// Streaming add/sub port bundle: operands in with valid/ready, result out with valid/ready.
// The DUT connects through 'slave'; a producer/consumer pair connects through 'master'.
interface pipelined_adder_if #(
    parameter int WIDTH = 16
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_op1;
    logic [WIDTH-1:0] i_op2;
    logic             i_carry_in;
    logic             i_sub;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_sum;
    logic             o_carry_out;
    logic             o_overflow;

    modport slave (
        input  i_valid, i_op1, i_op2, i_carry_in, i_sub, i_ready,
        output o_ready, o_valid, o_sum, o_carry_out, o_overflow
    );

    modport master (
        output i_valid, i_op1, i_op2, i_carry_in, i_sub, i_ready,
        input  o_ready, o_valid, o_sum, o_carry_out, o_overflow
    );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract, carry chain cut into STAGES registered slices; latency STAGES cycles.
// Backpressure: one global advance (!o_valid || i_ready) is o_ready and freezes every stage.
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    pipelined_adder_if.slave bus
);
    localparam int SW = WIDTH / STAGES;

    logic              adv;
    logic [WIDTH-1:0]  b_eff;
    logic [STAGES-1:0] vld_d, vld_q;
    logic              ovf_d, ovf_q;
    logic              a_msb, b_msb, s_msb;

    assign adv   = !vld_q[STAGES-1] || bus.i_ready;
    assign b_eff = bus.i_sub ? ~bus.i_op2 : bus.i_op2;

    // Bubbles shift through with the data; nothing is collapsed.
    always_comb begin
        vld_d = vld_q;
        if (adv) begin
            vld_d    = vld_q << 1;
            vld_d[0] = bus.i_valid;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
            ovf_q <= ovf_d;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int LO = k * SW;

        logic [WIDTH-LO-1:0] a_in, b_in;
        logic                c_in;
        logic [SW:0]         slice;
        logic [LO+SW-1:0]    sum_d, sum_q;
        logic                carry_d, carry_q;

        if (k == 0) begin : g_src
            assign a_in = bus.i_op1;
            assign b_in = b_eff;
            assign c_in = bus.i_carry_in;
        end else begin : g_src
            assign a_in = g_stg[k-1].g_skew.a_q;
            assign b_in = g_stg[k-1].g_skew.b_q;
            assign c_in = g_stg[k-1].carry_q;
        end

        assign slice = {1'b0, a_in[SW-1:0]} + {1'b0, b_in[SW-1:0]} + {{SW{1'b0}}, c_in};

        if (k == 0) begin : g_sum
            always_comb sum_d = adv ? slice[SW-1:0] : sum_q;
        end else begin : g_sum
            always_comb sum_d = adv ? {slice[SW-1:0], g_stg[k-1].sum_q} : sum_q;
        end

        always_comb carry_d = adv ? slice[SW] : carry_q;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                sum_q   <= '0;
                carry_q <= 1'b0;
            end else begin
                sum_q   <= sum_d;
                carry_q <= carry_d;
            end
        end

        // Skew registers carry only the operand slices later stages still need.
        if (k < STAGES - 1) begin : g_skew
            logic [WIDTH-LO-SW-1:0] a_d, a_q, b_d, b_q;

            always_comb begin
                a_d = adv ? a_in[WIDTH-LO-1:SW] : a_q;
                b_d = adv ? b_in[WIDTH-LO-1:SW] : b_q;
            end

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end
    end

    // Overflow is resolved in the last slice, where the operand sign bits live.
    assign a_msb = g_stg[STAGES-1].a_in[SW-1];
    assign b_msb = g_stg[STAGES-1].b_in[SW-1];
    assign s_msb = g_stg[STAGES-1].slice[SW-1];

    always_comb ovf_d = adv ? ((a_msb == b_msb) && (s_msb != a_msb)) : ovf_q;

    assign bus.o_ready     = adv;
    assign bus.o_valid     = vld_q[STAGES-1];
    assign bus.o_sum       = vld_q[STAGES-1] ? g_stg[STAGES-1].sum_q : '0;
    assign bus.o_carry_out = vld_q[STAGES-1] && g_stg[STAGES-1].carry_q;
    assign bus.o_overflow  = vld_q[STAGES-1] && ovf_q;
endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: table vectors, directed corner sequences, random streaming
// against an arithmetic model, plus random runs of three other WIDTH/STAGES shapes.
module tb_pipelined_adder;
    localparam int W = 16;
    localparam int S = 4;

    typedef struct packed {
        logic [W-1:0] op1;
        logic [W-1:0] op2;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int unsigned  cyc;
    } exp_t;

    logic        i_clk    = 1'b0;
    logic        rst_n    = 1'b1;
    logic        sw_rst_n = 1'b1;
    int          checks   = 0;
    int          failures = 0;
    int          n_out    = 0;
    int unsigned cyc      = 0;
    bit          lat_chk  = 1'b0;
    exp_t        sbq[$];
    exp_t        mon_e;
    vec_t        tbl[$];

    pipelined_adder_if #(.WIDTH(W)) pa ();

    pipelined_adder #(.WIDTH(W), .STAGES(S)) u_dut (
        .i_clk  (i_clk),
        .i_rst_n(rst_n),
        .bus    (pa.slave)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    initial begin
        #2 sw_rst_n = 1'b0;
        #10 sw_rst_n = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic, overflow as "true signed sum out of range".
    function automatic exp_t ref16(input logic [W-1:0] a, input logic [W-1:0] b2,
                                   input logic c, input logic s);
        exp_t         e;
        logic [W-1:0] b;
        logic [W:0]   full;
        int           r;
        b      = s ? ~b2 : b2;
        full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        r      = int'($signed(a)) + int'($signed(b)) + int'(c);
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (r > 32767) || (r < -32768);
        e.cyc  = 0;
        return e;
    endfunction

    always @(negedge i_clk) begin
        if (rst_n && pa.o_valid && pa.i_ready) begin
            n_out++;
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got sum 0x%0h, required no output", pa.o_sum);
            end else begin
                mon_e = sbq.pop_front();
                chk("result", {pa.o_carry_out, pa.o_sum}, {mon_e.cout, mon_e.sum});
                chk("overflow", pa.o_overflow, mon_e.ovf);
                if (lat_chk) chk("latency", cyc - mon_e.cyc, S);
            end
        end
    end

    // Entered just after a rising edge; returns just after the next one.
    task automatic step_drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic c, input logic s, input logic rdy,
                              input exp_t e, output bit acc);
        pa.i_valid = v; pa.i_op1 = a; pa.i_op2 = b;
        pa.i_carry_in = c; pa.i_sub = s; pa.i_ready = rdy;
        @(negedge i_clk);
        acc = v && pa.o_ready;
        if (acc) begin
            e.cyc = cyc;
            sbq.push_back(e);
        end
        @(posedge i_clk); #1;
    endtask

    task automatic drain();
        bit   acc_d;
        exp_t z;
        z = '0;
        for (int t = 0; t < 60 && sbq.size() != 0; t++)
            step_drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, z, acc_d);
        chk("drain_empty", sbq.size(), 0);
    endtask

    task automatic add_vec(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                           input logic s, input logic [W-1:0] sum, input logic co,
                           input logic ov);
        vec_t vv;
        vv.op1 = a; vv.op2 = b; vv.cin = c; vv.sub = s;
        vv.sum = sum; vv.cout = co; vv.ovf = ov;
        tbl.push_back(vv);
    endtask

    initial begin
        bit           acc;
        int           acc_n, n0, k, held;
        logic [W-1:0] a, b;
        logic         c, s, v, rdy;
        logic [W+1:0] snap;
        logic [W-1:0] cv[5];
        vec_t         bpv[10];
        exp_t         e;

        pa.i_valid = 1'b0; pa.i_op1 = '0; pa.i_op2 = '0;
        pa.i_carry_in = 1'b0; pa.i_sub = 1'b0; pa.i_ready = 1'b1;

        // Reset state, asserted asynchronously while the clock is low.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_o_valid", pa.o_valid, 0);
        chk("rst_o_sum", pa.o_sum, 0);
        chk("rst_o_carry", pa.o_carry_out, 0);
        chk("rst_o_ovf", pa.o_overflow, 0);
        chk("rst_o_ready", pa.o_ready, 1);
        @(negedge i_clk);
        @(negedge i_clk) rst_n = 1'b1;
        @(posedge i_clk); #1;

        cv = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                for (int cc = 0; cc < 2; cc++)
                    for (int ss = 0; ss < 2; ss++) begin
                        e = ref16(cv[i], cv[j], 1'(cc), 1'(ss));
                        add_vec(cv[i], cv[j], 1'(cc), 1'(ss), e.sum, e.cout, e.ovf);
                    end
        add_vec(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        add_vec(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        add_vec(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        add_vec(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

        // Back-to-back table stream, latency checked on every result.
        lat_chk = 1'b1;
        n0 = n_out;
        foreach (tbl[i]) begin
            e = '0;
            e.sum = tbl[i].sum; e.cout = tbl[i].cout; e.ovf = tbl[i].ovf;
            step_drive(1'b1, tbl[i].op1, tbl[i].op2, tbl[i].cin, tbl[i].sub, 1'b1, e, acc);
            chk("tbl_accept", acc, 1);
        end
        drain();
        chk("tbl_count", n_out - n0, tbl.size());

        // Backpressure: stall five cycles once the first result shows.
        lat_chk = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bpv[i] = '0;
            bpv[i].op1 = 16'($urandom); bpv[i].op2 = 16'($urandom);
            bpv[i].cin = 1'($urandom_range(0, 1)); bpv[i].sub = 1'($urandom_range(0, 1));
        end
        n0 = n_out; k = 0; held = 0; snap = '0;
        for (int t = 0; t < 200 && (k < 10 || sbq.size() != 0); t++) begin
            rdy = (held >= 5);
            pa.i_valid = (k < 10);
            pa.i_op1 = bpv[k % 10].op1; pa.i_op2 = bpv[k % 10].op2;
            pa.i_carry_in = bpv[k % 10].cin; pa.i_sub = bpv[k % 10].sub;
            pa.i_ready = rdy;
            @(negedge i_clk);
            if (!rdy && pa.o_valid) begin
                chk("bp_o_ready", pa.o_ready, 0);
                if (held == 0) snap = {pa.o_overflow, pa.o_carry_out, pa.o_sum};
                else chk("bp_stable", {pa.o_valid, pa.o_overflow, pa.o_carry_out, pa.o_sum}, {1'b1, snap});
                held++;
            end
            if (pa.i_valid && pa.o_ready) begin
                e = ref16(pa.i_op1, pa.i_op2, pa.i_carry_in, pa.i_sub);
                e.cyc = cyc;
                sbq.push_back(e);
                k++;
            end
            @(posedge i_clk); #1;
        end
        chk("bp_stall_cycles", held, 5);
        chk("bp_count", n_out - n0, 10);
        chk("bp_empty", sbq.size(), 0);

        // Random valid/ready streaming against the model.
        n0 = n_out; acc_n = 0;
        for (int t = 0; t < 20000 && acc_n < 1000; t++) begin
            v = ($urandom_range(0, 3) != 0); rdy = ($urandom_range(0, 3) != 0);
            a = 16'($urandom); b = 16'($urandom);
            c = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1));
            step_drive(v, a, b, c, s, rdy, ref16(a, b, c, s), acc);
            if (acc) acc_n++;
        end
        chk("rand_accepted", acc_n, 1000);
        drain();
        chk("rand_count", n_out - n0, 1000);

        // Asynchronous reset with three operations in flight.
        lat_chk = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 16'($urandom); b = 16'($urandom);
            step_drive(1'b1, a, b, 1'b0, 1'b0, 1'b1, ref16(a, b, 1'b0, 1'b0), acc);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_o_valid", pa.o_valid, 0);
        chk("mid_rst_outputs", {pa.o_overflow, pa.o_carry_out, pa.o_sum}, 0);
        chk("mid_rst_o_ready", pa.o_ready, 1);
        sbq.delete();
        @(negedge i_clk);
        @(posedge i_clk); #3 rst_n = 1'b1;
        n0 = n_out;
        e = '0;
        for (int i = 0; i < 6; i++) step_drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, e, acc);
        chk("no_stale_results", n_out - n0, 0);
        e.sum = 16'h5555;
        step_drive(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, e, acc);
        chk("post_rst_accept", acc, 1);
        drain();
        chk("post_rst_count", n_out - n0, 1);

        for (int t = 0; t < 10000 && !(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done); t++)
            @(posedge i_clk);
        chk("sweep_done", {g_sweep[0].done, g_sweep[1].done, g_sweep[2].done}, 3'b111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Other shapes: (4,1), (8,2), (32,8), each with its own model and scoreboard.
    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int SWP_W = (g == 0) ? 4 : (g == 1) ? 8 : 32;
        localparam int SWP_S = (g == 0) ? 1 : (g == 1) ? 2 : 8;
        typedef logic [SWP_W+1:0] res_t;

        pipelined_adder_if #(.WIDTH(SWP_W)) sif ();
        pipelined_adder #(.WIDTH(SWP_W), .STAGES(SWP_S)) u_dut (
            .i_clk  (i_clk),
            .i_rst_n(sw_rst_n),
            .bus    (sif.slave)
        );

        res_t q[$];
        res_t e;
        int   n_acc = 0;
        int   lat   = 0;
        bit   done  = 1'b0;

        function automatic res_t model(input logic [SWP_W-1:0] a, input logic [SWP_W-1:0] b2,
                                       input logic c, input logic s);
            logic [SWP_W-1:0] b;
            logic [SWP_W:0]   full;
            longint           r, lim;
            b    = s ? ~b2 : b2;
            full = {1'b0, a} + {1'b0, b} + {{SWP_W{1'b0}}, c};
            r    = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
            lim  = longint'(1) << (SWP_W - 1);
            return {(r >= lim) || (r < -lim), full};
        endfunction

        always @(negedge i_clk) begin
            if (sw_rst_n) begin
                if (sif.o_valid && sif.i_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sweep_w%0d_extra: got sum 0x%0h, required no output", SWP_W, sif.o_sum);
                    end else begin
                        e = q.pop_front();
                        chk($sformatf("sweep_w%0d_s%0d_result", SWP_W, SWP_S),
                            {sif.o_overflow, sif.o_carry_out, sif.o_sum}, e);
                    end
                end
                if (sif.i_valid && sif.o_ready) begin
                    q.push_back(model(sif.i_op1, sif.i_op2, sif.i_carry_in, sif.i_sub));
                    n_acc++;
                end
            end
        end

        initial begin
            sif.i_valid = 1'b0; sif.i_ready = 1'b1; sif.i_op1 = '0; sif.i_op2 = '0;
            sif.i_carry_in = 1'b0; sif.i_sub = 1'b0;
            @(posedge sw_rst_n);
            @(posedge i_clk); #1;
            sif.i_valid = 1'b1;
            sif.i_op1 = SWP_W'($urandom); sif.i_op2 = SWP_W'($urandom);
            sif.i_carry_in = 1'($urandom_range(0, 1));
            @(negedge i_clk);
            @(posedge i_clk); #1;
            sif.i_valid = 1'b0;
            lat = 1;
            @(negedge i_clk);
            while (!sif.o_valid && lat < 20) begin
                lat++;
                @(negedge i_clk);
            end
            chk($sformatf("sweep_w%0d_latency", SWP_W), lat, SWP_S);
            for (int t = 0; t < 6000 && n_acc < 301; t++) begin
                @(posedge i_clk); #1;
                sif.i_valid = ($urandom_range(0, 3) != 0);
                sif.i_ready = ($urandom_range(0, 3) != 0);
                sif.i_op1 = SWP_W'($urandom); sif.i_op2 = SWP_W'($urandom);
                sif.i_carry_in = 1'($urandom_range(0, 1)); sif.i_sub = 1'($urandom_range(0, 1));
            end
            @(posedge i_clk); #1;
            sif.i_valid = 1'b0; sif.i_ready = 1'b1;
            for (int t = 0; t < 40 && q.size() != 0; t++) @(negedge i_clk);
            chk($sformatf("sweep_w%0d_accepted", SWP_W), n_acc >= 301, 1);
            chk($sformatf("sweep_w%0d_drain", SWP_W), q.size(), 0);
            done = 1'b1;
        end
    end
endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined successor to the combinational four-bit adder. It adds or subtracts two WIDTH-bit operands with carry-in. The carry chain is split into STAGES slices, with one register stage per slice. A valid/ready handshake lets the block sit between streaming producers and consumers in the datapath, and it sustains one operation per clock when not stalled.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages (carry slices); 1 ≤ STAGES ≤ WIDTH; slice width SW = WIDTH/STAGES.
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_valid  input  1  input operation present this cycle.
- o_ready  output  1  block accepts the input this cycle.
- i_op1  input  WIDTH  first operand.
- i_op2  input  WIDTH  second operand.
- i_carry_in  input  1  carry into bit 0.
- i_sub  input  1  0: add, 1: subtract (op2 inverted).
- o_valid  output  1  result present.
- i_ready  input  1  downstream accepts the result.
- o_sum  output  WIDTH  result.
- o_carry_out  output  1  carry out of bit WIDTH-1.
- o_overflow  output  1  two's-complement signed overflow.

## Operation
- Effective operand: B = i_sub ? ~i_op2 : i_op2. Result: {o_carry_out, o_sum} = i_op1 + B + i_carry_in, computed modulo 2^(WIDTH+1).
  - Subtract: i_sub=1 with i_carry_in=1 gives op1−op2.
  - Borrow-in: i_sub=1 with i_carry_in=0 gives op1−op2−1.
- o_overflow = (op1[MSB] == B[MSB]) && (o_sum[MSB] != op1[MSB]).
- Stage k (k = 0..STAGES-1):
  - Adds operand slice k (bits k·SW .. k·SW+SW-1) plus the carry registered by stage k-1; stage 0 uses i_carry_in.
  - Registers the sum slice, the slice carry, and all not-yet-consumed operand slices (skew registers).
  - Forwards all sum slices already computed.
- Each stage holds a valid bit. The pipeline acts as one shift register with a global advance enable: adv = !o_valid || i_ready.
- o_ready = adv. A transfer occurs when i_valid && o_ready.
- On adv, every stage loads from its predecessor, and stage 0 loads i_valid. Bubbles are not collapsed.
- When adv=0, all stage registers, including valid bits and data, hold.
- An output transfer occurs when o_valid && i_ready. Results leave in input order; none are dropped or duplicated.
- Data registers of invalid stages are don't-care internally, but o_sum, o_carry_out and o_overflow read 0 whenever o_valid=0.

## Timing
- Reset (i_rst_n=0, asynchronous, any time):
  - All valid bits clear immediately: o_valid=0, o_sum=0, o_carry_out=0, o_overflow=0.
  - o_ready=1 (combinational from o_valid=0).
  - In-flight operations are discarded.
  - The first accept is on the first rising edge with i_rst_n=1.
- Latency is exactly STAGES cycles. An operation accepted at edge n appears with o_valid=1 after edge n+STAGES-1 and is presented during cycle n+STAGES, provided no stall occurred.
- Throughput: 1 result/clock with i_valid=1 and i_ready=1 held.
- Stall: while o_valid=1 and i_ready=0, o_ready=0, and o_sum, o_carry_out, o_overflow and o_valid are stable.
- o_ready depends combinationally on i_ready (no skid buffer). The upstream side must not create a combinational loop back to i_ready.
- i_valid, i_op1, i_op2, i_carry_in and i_sub are sampled only on accept edges. Upstream may change them freely otherwise.
- STAGES=1 degenerates to a single registered full-width adder with latency 1.

## Test plan
All scenarios use WIDTH=16, STAGES=4.

- Exhaustive corners: op1, op2 ∈ {0x0000, 0x0001, 0x7FFF, 0x8000, 0xFFFF}, all pairs × carry_in ∈ {0,1} × sub ∈ {0,1}, streamed back-to-back with i_ready=1.
  - Each {o_carry_out, o_sum} matches the reference model exactly using !== compares.
  - One result per clock after a 4-cycle fill.
- Carry ripple across all slices: 0xFFFF + 0x0000 + carry_in=1 → o_sum=0x0000, o_carry_out=1, o_overflow=0. Result appears exactly 4 cycles after accept.
- Signed overflow:
  - 0x7FFF + 0x0001 → o_sum=0x8000, o_overflow=1, o_carry_out=0.
  - sub: 0x8000 − 0x0001 (carry_in=1) → o_sum=0x7FFF, o_overflow=1, o_carry_out=1.
- Backpressure:
  - Stream 10 random operations.
  - Hold i_ready=0 for 5 cycles once o_valid=1: o_ready=0 throughout, outputs stable.
  - Release: all 10 results arrive in order with no loss or duplicates.
  - Run 1000 random ops with random i_valid/i_ready and an error counter that ends at 0.
- Asynchronous reset mid-stream:
  - Assert i_rst_n=0 between clock edges while 3 operations are in flight: o_valid drops to 0 immediately and outputs read 0.
  - After release, none of the old results appear.
  - A new op 0x1234 + 0x4321 yields 0x5555 after 4 cycles.
- Parameter sweep: rerun the random test with (WIDTH, STAGES) = (4,1), (8,2), (32,8) → zero mismatches, latency equals STAGES.
